// File: rtl/let_expr_unit.sv
// Registered evaluator for shared let expressions: arbitration, multiply, eq, range, stream reorders.
// One-cycle latency from in_valid to out_valid; no backpressure, results hold while in_valid is low.
module let_expr_unit #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int DW = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     request,
  input  logic [N-1:0]     valid,
  input  logic             override,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     b,
  input  logic             use_y,
  input  logic [7:0]       value,
  input  logic [DW-1:0]    word,
  output logic             out_valid,
  output logic             grant,
  output logic [2*W-1:0]   product,
  output logic             eq,
  output logic             in_range,
  output logic [DW-1:0]    rev_byte,
  output logic [DW-1:0]    rev_half,
  output logic [DW-1:0]    rev_bit
);

  localparam int NB = DW / 8;
  localparam int NH = DW / 16;

  logic             w_grant;
  logic [2*W-1:0]   w_product;
  logic             w_eq;
  logic             w_in_range;
  logic [DW-1:0]    w_rev_byte;
  logic [DW-1:0]    w_rev_half;
  logic [DW-1:0]    w_rev_bit;

  logic             r_out_valid;
  logic             r_grant;
  logic [2*W-1:0]   r_product;
  logic             r_eq;
  logic             r_in_range;
  logic [DW-1:0]    r_rev_byte;
  logic [DW-1:0]    r_rev_half;
  logic [DW-1:0]    r_rev_bit;

  assign w_grant    = (|(request & valid)) || override;
  assign w_product  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
  assign w_eq       = (x == (use_y ? y : b));
  assign w_in_range = ((value >= 8'd16) && (value <= 8'd23)) ||
                      ((value >= 8'd32) && (value <= 8'd47));

  // Chunk order within rev_half is reversed, bytes inside each chunk keep their order.
  always_comb begin
    w_rev_byte = '0;
    w_rev_half = '0;
    w_rev_bit  = '0;
    for (int i = 0; i < NB; i++) w_rev_byte[i*8 +: 8]   = word[(NB-1-i)*8 +: 8];
    for (int i = 0; i < NH; i++) w_rev_half[i*16 +: 16] = word[(NH-1-i)*16 +: 16];
    for (int i = 0; i < DW; i++) w_rev_bit[i]           = word[DW-1-i];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_grant     <= 1'b0;
      r_product   <= '0;
      r_eq        <= 1'b0;
      r_in_range  <= 1'b0;
      r_rev_byte  <= '0;
      r_rev_half  <= '0;
      r_rev_bit   <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_grant    <= w_grant;
        r_product  <= w_product;
        r_eq       <= w_eq;
        r_in_range <= w_in_range;
        r_rev_byte <= w_rev_byte;
        r_rev_half <= w_rev_half;
        r_rev_bit  <= w_rev_bit;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign grant     = r_grant;
  assign product   = r_product;
  assign eq        = r_eq;
  assign in_range  = r_in_range;
  assign rev_byte  = r_rev_byte;
  assign rev_half  = r_rev_half;
  assign rev_bit   = r_rev_bit;

endmodule

// File: tb/tb_let_expr_unit.sv
// Directed-vector bench for let_expr_unit with hand-computed expectations.
module tb_let_expr_unit;

  logic        clock;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  request;
  logic [3:0]  valid;
  logic        override;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  b;
  logic        use_y;
  logic [7:0]  value;
  logic [31:0] word;
  logic        out_valid;
  logic        grant;
  logic [15:0] product;
  logic        eq;
  logic        in_range;
  logic [31:0] rev_byte;
  logic [31:0] rev_half;
  logic [31:0] rev_bit;

  int n_vec  = 0;
  int n_fail = 0;

  let_expr_unit #(.N(4), .W(8), .DW(32)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .request  (request),
    .valid    (valid),
    .override (override),
    .x        (x),
    .y        (y),
    .b        (b),
    .use_y    (use_y),
    .value    (value),
    .word     (word),
    .out_valid(out_valid),
    .grant    (grant),
    .product  (product),
    .eq       (eq),
    .in_range (in_range),
    .rev_byte (rev_byte),
    .rev_half (rev_half),
    .rev_bit  (rev_bit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic issue();
    @(negedge clock);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"},   out_valid, 0);
    check({tag, "_gr"},   grant,     0);
    check({tag, "_prod"}, product,   0);
    check({tag, "_eq"},   eq,        0);
    check({tag, "_rng"},  in_range,  0);
    check({tag, "_rb"},   rev_byte,  0);
    check({tag, "_rh"},   rev_half,  0);
    check({tag, "_rbit"}, rev_bit,   0);
  endtask

  initial begin
    int vals[8];
    bit exp_rng[8];
    vals    = '{15, 16, 23, 24, 31, 32, 47, 48};
    exp_rng = '{0, 1, 1, 0, 0, 1, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; request = '0; valid = '0; override = 1'b0;
    x = '0; y = '0; b = '0; use_y = 1'b0; value = '0; word = '0;
    #12;
    check_zero("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // Arbitration vectors
    request = 4'b1010; valid = 4'b0101; override = 1'b0;
    issue();
    check("arb_disjoint", grant, 0);
    check("arb_disjoint_ov", out_valid, 1);
    @(negedge clock); override = 1'b1;
    @(posedge clock); #1;
    check("arb_override", grant, 1);
    @(negedge clock); request = 4'b0100; valid = 4'b0110; override = 1'b0;
    @(posedge clock); #1;
    check("arb_overlap", grant, 1);

    // Multiply and equality, with latency checked on both sides of the edge
    idle();
    @(posedge clock); #1;
    check("lat_idle_ov", out_valid, 0);
    @(negedge clock);
    x = 8'hFF; y = 8'hFF; use_y = 1'b1; b = 8'h00;
    in_valid = 1'b1;
    #2;
    check("lat_pre_edge_ov", out_valid, 0);
    @(posedge clock); #1;
    check("mul_ff_ff", product, 16'hFE01);
    check("mul_ov", out_valid, 1);
    check("eq_ff_ff", eq, 1);
    @(negedge clock); x = 8'h05; y = 8'h05; use_y = 1'b1; b = 8'h06;
    @(posedge clock); #1;
    check("eq_use_y", eq, 1);
    check("mul_5_5", product, 16'd25);
    @(negedge clock); use_y = 1'b0;
    @(posedge clock); #1;
    check("eq_use_b", eq, 0);
    @(negedge clock); b = 8'h05;
    @(posedge clock); #1;
    check("eq_use_b_match", eq, 1);

    // Range boundaries
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); value = vals[i][7:0];
      @(posedge clock); #1;
      check($sformatf("range_%0d", vals[i]), in_range, exp_rng[i]);
    end

    // Stream reorders
    @(negedge clock); word = 32'h41424344;
    @(posedge clock); #1;
    check("rev_byte", rev_byte, 32'h44434241);
    check("rev_half", rev_half, 32'h43444142);
    check("rev_bit",  rev_bit,  32'h22C24282);
    @(negedge clock); word = 32'h80000001;
    @(posedge clock); #1;
    check("rev_bit_ends", rev_bit, 32'h80000001);
    check("rev_byte_ends", rev_byte, 32'h01000080);

    // Throughput: four back-to-back operands
    y = 8'd3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock); x = k[7:0];
      @(posedge clock); #1;
      check($sformatf("thru_prod_%0d", k), product, 3 * k);
      check($sformatf("thru_ov_%0d", k), out_valid, 1);
    end
    @(negedge clock); in_valid = 1'b0; x = 8'd9; word = 32'hDEADBEEF;
    @(posedge clock); #1;
    check("hold_ov", out_valid, 0);
    check("hold_prod", product, 16'd12);
    check("hold_rev_byte", rev_byte, 32'h01000080);

    // Reset asserted while a result is valid
    @(negedge clock); x = 8'h10; y = 8'h10; in_valid = 1'b1;
    @(posedge clock); #1;
    check("pre_rst_ov", out_valid, 1);
    check("pre_rst_prod", product, 16'h0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(negedge clock); in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_ov", out_valid, 0);
    check("post_rst_prod", product, 0);
    @(posedge clock); #1;
    check("post_rst_ov2", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
